// File: rtl/checkseq_mc.sv
// checkseq_mc: multi-channel ADC input-test sequencer (checker reset pulse, timed enable window, error accumulation).
// Optional continuous mode is enabled by defining CHECKSEQ_CONT_EN (adds the cont input).
module checkseq_mc #(
  parameter int NCH    = 16,
  parameter int CNTW   = 32,
  parameter int BASE   = 16,
  parameter int STEP   = 2,
  parameter int ERRW   = 8,
  parameter int RSTLEN = 4,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      cntmax,
  input  logic [NCH-1:0]  err,
  input  logic [SELW-1:0] err_sel,
`ifdef CHECKSEQ_CONT_EN
  input  logic            cont,
`endif
  output logic            chk_reset,
  output logic            enable,
  output logic            ready,
  output logic            done,
  output logic            aborted,
  output logic [NCH-1:0]  err_any,
  output logic [ERRW-1:0] err_cnt
);

  localparam int RSTW = (RSTLEN > 1) ? $clog2(RSTLEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              start_d_r;
  logic              trig_s;
  logic              cont_s;
  logic              chk_reset_r, chk_reset_s;
  logic              enable_r, enable_s;
  logic              ready_r, ready_s;
  logic              done_r, done_s;
  logic              aborted_r, aborted_s;
  logic              clr_s;
  logic [2:0]        cntmax_r, cntmax_s;
  logic [CNTW-1:0]   win_cnt_r, win_cnt_s;
  logic [RSTW-1:0]   rst_cnt_r, rst_cnt_s;
  logic [ERRW-1:0]   cnt_r [NCH];
  logic [NCH-1:0]    err_any_r;
  logic [ERRW-1:0]   err_cnt_r;

  // Window length 2**(BASE+STEP*code), saturating to all-ones once the exponent reaches CNTW.
  function automatic logic [CNTW-1:0] win_len_f(input logic [2:0] code);
    int unsigned e;
    logic [CNTW-1:0] n;
    e = BASE + STEP * int'(code);
    if (e >= CNTW) begin
      n = {CNTW{1'b1}};
    end else begin
      n = CNTW'(1) << e;
    end
    return n;
  endfunction

`ifdef CHECKSEQ_CONT_EN
  assign cont_s = cont;
`else
  assign cont_s = 1'b0;
`endif

  assign trig_s = start & ~start_d_r;

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_s     = state_r;
    chk_reset_s = chk_reset_r;
    enable_s    = enable_r;
    ready_s     = ready_r;
    done_s      = 1'b0;
    aborted_s   = aborted_r;
    clr_s       = 1'b0;
    cntmax_s    = cntmax_r;
    win_cnt_s   = win_cnt_r;
    rst_cnt_s   = rst_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_s     = ST_RST;
          chk_reset_s = 1'b1;
          enable_s    = 1'b0;
          ready_s     = 1'b0;
          aborted_s   = 1'b0;
          clr_s       = 1'b1;
          cntmax_s    = cntmax;
          rst_cnt_s   = RSTW'(RSTLEN - 1);
        end else begin
          chk_reset_s = 1'b0;
          enable_s    = 1'b0;
          ready_s     = 1'b1;
        end
      end
      ST_RST: begin
        if (abort) begin
          state_s     = ST_IDLE;
          chk_reset_s = 1'b0;
          enable_s    = 1'b0;
          ready_s     = 1'b1;
          aborted_s   = 1'b1;
        end else if (rst_cnt_r == RSTW'(0)) begin
          state_s     = ST_RUN;
          chk_reset_s = 1'b0;
          enable_s    = 1'b1;
          win_cnt_s   = win_len_f(cntmax_r);
        end else begin
          rst_cnt_s   = rst_cnt_r - RSTW'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s     = ST_IDLE;
          chk_reset_s = 1'b0;
          enable_s    = 1'b0;
          ready_s     = 1'b1;
          aborted_s   = 1'b1;
        end else if (win_cnt_r == CNTW'(1)) begin
          enable_s = 1'b0;
          done_s   = 1'b1;
          // Continuous mode re-enters the reset pulse without clearing the accumulated results.
          if (cont_s) begin
            state_s     = ST_RST;
            chk_reset_s = 1'b1;
            cntmax_s    = cntmax;
            rst_cnt_s   = RSTW'(RSTLEN - 1);
          end else begin
            state_s     = ST_IDLE;
            ready_s     = 1'b1;
          end
        end else begin
          win_cnt_s = win_cnt_r - CNTW'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        chk_reset_s = 1'b0;
        enable_s    = 1'b0;
        ready_s     = 1'b1;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      start_d_r   <= 1'b0;
      chk_reset_r <= 1'b0;
      enable_r    <= 1'b0;
      ready_r     <= 1'b1;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      cntmax_r    <= 3'd0;
      win_cnt_r   <= {CNTW{1'b0}};
      rst_cnt_r   <= {RSTW{1'b0}};
    end else begin
      state_r     <= state_s;
      start_d_r   <= start;
      chk_reset_r <= chk_reset_s;
      enable_r    <= enable_s;
      ready_r     <= ready_s;
      done_r      <= done_s;
      aborted_r   <= aborted_s;
      cntmax_r    <= cntmax_s;
      win_cnt_r   <= win_cnt_s;
      rst_cnt_r   <= rst_cnt_s;
    end
  end

  // Per-channel saturating error counters and sticky flags, gated by the registered enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= {ERRW{1'b0}};
      end
      err_any_r <= {NCH{1'b0}};
    end else if (clr_s) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i] <= {ERRW{1'b0}};
      end
      err_any_r <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (enable_r && err[i]) begin
          if (cnt_r[i] != {ERRW{1'b1}}) begin
            cnt_r[i] <= cnt_r[i] + ERRW'(1);
          end else begin
            cnt_r[i] <= cnt_r[i];
          end
          err_any_r[i] <= 1'b1;
        end else begin
          cnt_r[i]     <= cnt_r[i];
          err_any_r[i] <= err_any_r[i];
        end
      end
    end
  end

  // Registered readout mux of the selected channel count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= {ERRW{1'b0}};
    end else if (int'(err_sel) < NCH) begin
      err_cnt_r <= cnt_r[err_sel];
    end else begin
      err_cnt_r <= {ERRW{1'b0}};
    end
  end

  assign chk_reset = chk_reset_r;
  assign enable    = enable_r;
  assign ready     = ready_r;
  assign done      = done_r;
  assign aborted   = aborted_r;
  assign err_any   = err_any_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_checkseq_mc.sv
// Directed self-checking bench for checkseq_mc: small-window instance u0 and a saturating-window instance u1.
module tb_checkseq_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort;
  logic [2:0] cntmax;
  logic [3:0] err;
  logic [1:0] err_sel;
  logic       chk_reset, enable, ready, done, aborted;
  logic [3:0] err_any, err_cnt;

  logic       reset1, start1, abort1;
  logic [2:0] cntmax1;
  logic [3:0] err1;
  logic [1:0] err_sel1;
  logic       chk_reset1, enable1, ready1, done1, aborted1;
  logic [3:0] err_any1, err_cnt1;
`ifdef CHECKSEQ_CONT_EN
  logic       cont, cont1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_rst, n_en, n_done, done_at;

  checkseq_mc #(.NCH(4), .CNTW(32), .BASE(2), .STEP(1), .ERRW(4), .RSTLEN(3)) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cntmax(cntmax),
    .err(err), .err_sel(err_sel),
`ifdef CHECKSEQ_CONT_EN
    .cont(cont),
`endif
    .chk_reset(chk_reset), .enable(enable), .ready(ready), .done(done),
    .aborted(aborted), .err_any(err_any), .err_cnt(err_cnt)
  );

  checkseq_mc #(.NCH(4), .CNTW(8), .BASE(6), .STEP(1), .ERRW(4), .RSTLEN(3)) u1 (
    .clk(clk), .reset(reset1), .start(start1), .abort(abort1), .cntmax(cntmax1),
    .err(err1), .err_sel(err_sel1),
`ifdef CHECKSEQ_CONT_EN
    .cont(cont1),
`endif
    .chk_reset(chk_reset1), .enable(enable1), .ready(ready1), .done(done1),
    .aborted(aborted1), .err_any(err_any1), .err_cnt(err_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges on u0, counting sampled chk_reset/enable/done; done_at is the edge index of the last done.
  task automatic run(input int n, output int o_rst, output int o_en, output int o_done, output int o_at);
    o_rst = 0; o_en = 0; o_done = 0; o_at = -1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (chk_reset) o_rst++;
      if (enable) o_en++;
      if (done) begin
        o_done++;
        o_at = k;
      end
    end
  endtask

  task automatic run1(input int n, output int o_en, output int o_done);
    o_en = 0; o_done = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (enable1) o_en++;
      if (done1) o_done++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; cntmax = 3'd0; err = 4'd0; err_sel = 2'd0;
    reset1 = 1'b0; start1 = 1'b0; abort1 = 1'b0; cntmax1 = 3'd0; err1 = 4'd0; err_sel1 = 2'd0;
`ifdef CHECKSEQ_CONT_EN
    cont = 1'b0; cont1 = 1'b0;
`endif
    #1;
    reset = 1'b1; reset1 = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_enable", enable, 0);
    chk("rst_chk_reset", chk_reset, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_err_any", err_any, 0);
    chk("rst_err_cnt", err_cnt, 0);
    repeat (3) tick();
    reset = 1'b0; reset1 = 1'b0;
    tick();

    // Basic sequence: cntmax=1 -> 3 reset cycles, 8 enable cycles, done on edge 12.
    cntmax = 3'd1; start = 1'b1;
    run(20, n_rst, n_en, n_done, done_at);
    start = 1'b0;
    chk("basic_rst_cycles", n_rst, 3);
    chk("basic_en_cycles", n_en, 8);
    chk("basic_done_count", n_done, 1);
    chk("basic_done_latency", done_at, 12);
    chk("basic_ready", ready, 1);
    chk("basic_aborted", aborted, 0);
    tick();

    // Error counting: ch2 erroring across a 16-cycle window saturates at 15.
    err_sel = 2'd2; cntmax = 3'd2; err = 4'b0100; start = 1'b1;
    run(20, n_rst, n_en, n_done, done_at);
    err = 4'b0000; start = 1'b0;
    chk("errc_en_cycles", n_en, 16);
    chk("errc_done_count", n_done, 1);
    tick(); tick();
    chk("errc_cnt_ch2", err_cnt, 15);
    chk("errc_err_any", err_any, 4'b0100);
    err_sel = 2'd0;
    tick(); tick();
    chk("errc_cnt_ch0", err_cnt, 0);

    // Abort on the 5th enable cycle; err on ch1 from the trigger (RST cycles must not count).
    err_sel = 2'd1; cntmax = 3'd3; err = 4'b0010; start = 1'b1;
    run(8, n_rst, n_en, n_done, done_at);
    chk("abort_en_before", n_en, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0; err = 4'b0000; start = 1'b0;
    chk("abort_enable", enable, 0);
    chk("abort_ready", ready, 1);
    chk("abort_aborted", aborted, 1);
    chk("abort_done", done, 0);
    run(40, n_rst, n_en, n_done, done_at);
    chk("abort_no_done", n_done, 0);
    chk("abort_no_enable", n_en, 0);
    chk("abort_partial_cnt", err_cnt, 5);
    chk("abort_err_any", err_any, 4'b0010);
    err_sel = 2'd2;
    tick(); tick();
    chk("abort_cleared_ch2", err_cnt, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_ready", ready, 1);
    chk("idle_abort_sticky", aborted, 1);

    // Trigger and abort together in IDLE: trigger wins. Then start held high -> one sequence only.
    cntmax = 3'd0; abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0;
    chk("trig_wins_chk_reset", chk_reset, 1);
    chk("trig_wins_aborted", aborted, 0);
    run(40, n_rst, n_en, n_done, done_at);
    chk("held_done_count", n_done, 1);
    chk("held_en_cycles", n_en, 4);
    chk("held_ready", ready, 1);
    start = 1'b0;
    tick();
    start = 1'b1;
    run(20, n_rst, n_en, n_done, done_at);
    chk("rerise_done_count", n_done, 1);
    start = 1'b0;
    tick();

    // Saturated window on u1: exponent 9 and exponent 8 (== CNTW) both give 255 cycles.
    cntmax1 = 3'd3; start1 = 1'b1;
    tick();
    run1(300, n_en, n_done);
    chk("sat_e9_en_cycles", n_en, 255);
    chk("sat_e9_done", n_done, 1);
    start1 = 1'b0;
    tick();
    cntmax1 = 3'd2; start1 = 1'b1;
    tick();
    run1(300, n_en, n_done);
    chk("sat_e8_en_cycles", n_en, 255);
    start1 = 1'b0;
    tick();

    // Async reset mid-window takes effect without a clock edge.
    cntmax1 = 3'd3; start1 = 1'b1;
    repeat (10) tick();
    chk("areset_pre_enable", enable1, 1);
    #2;
    reset1 = 1'b1;
    #1;
    chk("areset_enable", enable1, 0);
    chk("areset_ready", ready1, 1);
    chk("areset_chk_reset", chk_reset1, 0);
    tick();
    reset1 = 1'b0; start1 = 1'b0;
    tick();

`ifdef CHECKSEQ_CONT_EN
    // Continuous mode: two passes of 3 reset + 4 enable cycles, counts accumulate.
    cont = 1'b1; cntmax = 3'd0; err = 4'b1000; err_sel = 2'd3; start = 1'b1;
    run(14, n_rst, n_en, n_done, done_at);
    chk("cont_rst_cycles", n_rst, 6);
    chk("cont_en_cycles", n_en, 8);
    chk("cont_done_count", n_done, 1);
    chk("cont_done_at", done_at, 8);
    chk("cont_ready_low", ready, 0);
    cont = 1'b0;
    run(10, n_rst, n_en, n_done, done_at);
    err = 4'b0000; start = 1'b0;
    chk("cont_end_done_at", done_at, 1);
    chk("cont_end_done_count", n_done, 1);
    chk("cont_end_ready", ready, 1);
    tick(); tick();
    chk("cont_accum_cnt", err_cnt, 8);
    chk("cont_err_any", err_any, 4'b1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
